// File: rtl/swsr_frame_wr_ctrl.sv
// Frame write controller for the single-write/single-read frame DPRAM: writes each delimited
// frame from address 0, checks length and additive checksum, and holds a good frame until acked.
module swsr_frame_wr_ctrl #(
    parameter int DEPTH      = 138,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_vld,
    input  logic                  rx_sof,
    input  logic                  rx_eof,
    input  logic [DATA_WIDTH-1:0] rx_data,
    output logic                  wren,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  frm_rdy,
    output logic [ADDR_WIDTH-1:0] frm_len,
    input  logic                  frm_ack,
    output logic                  err_sum,
    output logic                  err_ovf,
    output logic [CNT_WIDTH-1:0]  drop_cnt
);

    typedef enum logic [1:0] {IDLE, RECV, HOLD, DROP} state_t;

    localparam logic [ADDR_WIDTH-1:0] DEPTH_C = ADDR_WIDTH'(DEPTH);

    state_t                  state_q,    state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q,      cnt_d;
    logic [DATA_WIDTH-1:0]   sum_q,      sum_d;
    logic                    wren_q,     wren_d;
    logic [ADDR_WIDTH-1:0]   waddr_q,    waddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q,    wdata_d;
    logic                    frm_rdy_q,  frm_rdy_d;
    logic [ADDR_WIDTH-1:0]   frm_len_q,  frm_len_d;
    logic                    err_sum_q,  err_sum_d;
    logic                    err_ovf_q,  err_ovf_d;
    logic [CNT_WIDTH-1:0]    drop_cnt_q, drop_cnt_d;
    logic                    start_frame;

    // NOTE: every _d gets a default before the case, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        wren_d      = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        frm_rdy_d   = frm_rdy_q;
        frm_len_d   = frm_len_q;
        err_sum_d   = 1'b0;
        err_ovf_d   = 1'b0;
        drop_cnt_d  = drop_cnt_q;
        start_frame = 1'b0;

        unique case (state_q)
            IDLE, DROP: begin
                if (rx_vld && rx_sof) begin
                    start_frame = 1'b1;
                end else if (state_q == DROP && rx_vld && rx_eof) begin
                    state_d = IDLE;
                end
            end
            RECV: begin
                if (rx_vld) begin
                    if (rx_sof) begin
                        start_frame = 1'b1;
                    end else if (cnt_q == DEPTH_C) begin
                        err_ovf_d = 1'b1;
                        state_d   = rx_eof ? IDLE : DROP;
                    end else begin
                        wren_d  = 1'b1;
                        waddr_d = cnt_q;
                        wdata_d = rx_data;
                        if (rx_eof) begin
                            if (sum_q == rx_data) begin
                                frm_rdy_d = 1'b1;
                                frm_len_d = cnt_q + ADDR_WIDTH'(1);
                                state_d   = HOLD;
                            end else begin
                                err_sum_d = 1'b1;
                                state_d   = IDLE;
                            end
                        end else begin
                            sum_d = sum_q + rx_data;
                            cnt_d = cnt_q + ADDR_WIDTH'(1);
                        end
                    end
                end
            end
            HOLD: begin
                // A frame starting while we hold is refused, even when the ack lands in the same cycle.
                if (rx_vld && rx_sof && drop_cnt_q != '1) begin
                    drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
                end
                if (frm_ack) begin
                    frm_rdy_d = 1'b0;
                    frm_len_d = '0;
                    state_d   = IDLE;
                end
            end
        endcase

        if (start_frame) begin
            wren_d  = 1'b1;
            waddr_d = '0;
            wdata_d = rx_data;
            sum_d   = rx_data;
            cnt_d   = ADDR_WIDTH'(1);
            if (rx_eof) begin
                err_sum_d = 1'b1;
                state_d   = IDLE;
            end else begin
                state_d   = RECV;
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sum_q      <= '0;
            wren_q     <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            frm_rdy_q  <= 1'b0;
            frm_len_q  <= '0;
            err_sum_q  <= 1'b0;
            err_ovf_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            wren_q     <= wren_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            frm_rdy_q  <= frm_rdy_d;
            frm_len_q  <= frm_len_d;
            err_sum_q  <= err_sum_d;
            err_ovf_q  <= err_ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign wren     = wren_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign frm_rdy  = frm_rdy_q;
    assign frm_len  = frm_len_q;
    assign err_sum  = err_sum_q;
    assign err_ovf  = err_ovf_q;
    assign drop_cnt = drop_cnt_q;

endmodule
